dram_bridge: RTL

Data-memory responder for the MEM stage. Accepts the word-wide, byte-selected data-RAM request that MEM drives (chip enable, write enable, 4-bit byte select, address, store data). Serialises each request onto an 8-bit synchronous external SRAM bus, one byte lane per cycle. Holds the pipeline through the stall controller until load data is assembled or store bytes are written.

---
 rtl/dram_bridge_pkg.sv | 24 ++
 rtl/dram_bridge.sv | 122 ++++++++++++
 2 files changed

// File: rtl/dram_bridge_pkg.sv
// Shared constants, state encoding and lane-search helper for the MEM-stage SRAM bridge.
package dram_bridge_pkg;

    localparam logic        RstEnable   = 1'b0;
    localparam logic        ChipEnable  = 1'b1;
    localparam logic        WriteEnable = 1'b1;
    localparam logic [31:0] ZeroWord    = 32'h0000_0000;

    typedef enum logic [1:0] {
        DbIdle   = 2'd0,
        DbAccess = 2'd1,
        DbLast   = 2'd2,
        DbDone   = 2'd3
    } db_state_e;

    // Lowest set lane of a remaining-lane mask; 0 when the mask is empty.
    function automatic logic [1:0] first_lane(input logic [3:0] mask);
        first_lane = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i]) first_lane = 2'(i);
        end
    endfunction

endpackage

// File: rtl/dram_bridge.sv
// Serialises word-wide byte-selected MEM requests onto an 8-bit synchronous SRAM,
// one selected lane per cycle, stalling the pipeline until the access completes.
module dram_bridge
    import dram_bridge_pkg::*;
#(
    parameter int unsigned RAM_ADDR_W = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_ce_i,
    input  logic                  mem_we_i,
    input  logic [3:0]            mem_sel_i,
    input  logic [31:0]           mem_addr_i,
    input  logic [31:0]           mem_data_i,
    output logic [31:0]           mem_data_o,
    output logic                  stall_req_o,
    output logic [RAM_ADDR_W-1:0] ram_addr_o,
    output logic                  ram_we_o,
    output logic [7:0]            ram_dout_o,
    input  logic [7:0]            ram_din_i
);

    localparam int unsigned WordAddrW = RAM_ADDR_W - 2;

    db_state_e            state;
    logic                 we_q;
    logic [3:0]           pend_q;
    logic [WordAddrW-1:0] word_q;
    logic [31:0]          wdata_q;
    logic [1:0]           prev_lane_q;
    logic                 prev_vld_q;

    logic                 idle_c;
    logic [WordAddrW-1:0] word_c;
    logic [3:0]           mask_c;
    logic [1:0]           lane_c;
    logic [31:0]          src_data_c;
    logic [7:0]           byte_c;
    logic [3:0]           rest_c;
    logic                 unused_addr_bits;

    assign unused_addr_bits = ^{mem_addr_i[31:RAM_ADDR_W], mem_addr_i[1:0]};

    // Next lane to issue: taken from the live request in IDLE, else from the pending mask.
    always_comb begin
        idle_c     = (state == DbIdle);
        word_c     = idle_c ? mem_addr_i[RAM_ADDR_W-1:2] : word_q;
        mask_c     = idle_c ? mem_sel_i : pend_q;
        src_data_c = idle_c ? mem_data_i : wdata_q;
        lane_c     = first_lane(mask_c);
        byte_c     = 8'(src_data_c >> {lane_c, 3'b000});
        rest_c     = mask_c & ~(4'b0001 << lane_c);
    end

    assign stall_req_o = (rst != RstEnable) &&
                         ((idle_c && (mem_ce_i == ChipEnable)) ||
                          (state == DbAccess) || (state == DbLast));

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state       <= DbIdle;
            mem_data_o  <= ZeroWord;
            ram_addr_o  <= '0;
            ram_dout_o  <= 8'h00;
            ram_we_o    <= 1'b0;
            we_q        <= 1'b0;
            pend_q      <= 4'b0000;
            word_q      <= '0;
            wdata_q     <= ZeroWord;
            prev_lane_q <= 2'd0;
            prev_vld_q  <= 1'b0;
        end else begin
            case (state)
                DbIdle: begin
                    if (mem_ce_i == ChipEnable) begin
                        we_q       <= mem_we_i;
                        word_q     <= word_c;
                        wdata_q    <= mem_data_i;
                        prev_vld_q <= 1'b0;
                        if (mem_we_i != WriteEnable) mem_data_o <= ZeroWord;
                        if (mem_sel_i == 4'b0000) begin
                            pend_q <= 4'b0000;
                            state  <= DbDone;
                        end else begin
                            ram_addr_o <= {word_c, lane_c};
                            ram_dout_o <= byte_c;
                            ram_we_o   <= (mem_we_i == WriteEnable);
                            pend_q     <= rest_c;
                            state      <= DbAccess;
                        end
                    end
                end
                DbAccess: begin
                    // Read data trails its address by one cycle.
                    if ((we_q != WriteEnable) && prev_vld_q)
                        mem_data_o[{prev_lane_q, 3'b000} +: 8] <= ram_din_i;
                    prev_lane_q <= ram_addr_o[1:0];
                    prev_vld_q  <= 1'b1;
                    if (pend_q != 4'b0000) begin
                        ram_addr_o <= {word_c, lane_c};
                        ram_dout_o <= byte_c;
                        pend_q     <= rest_c;
                    end else begin
                        ram_we_o <= 1'b0;
                        state    <= (we_q == WriteEnable) ? DbDone : DbLast;
                    end
                end
                DbLast: begin
                    mem_data_o[{prev_lane_q, 3'b000} +: 8] <= ram_din_i;
                    state <= DbDone;
                end
                DbDone: begin
                    state <= DbIdle;
                end
                default: begin
                    state <= DbIdle;
                end
            endcase
        end
    end

endmodule
